// File: rtl/page_map_bank_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for the page map bank.
package page_map_bank_pkg;

  localparam logic [2:0] OP_NONE      = 3'd0;
  localparam logic [2:0] OP_ADD       = 3'd1;
  localparam logic [2:0] OP_REMOVE    = 3'd2;
  localparam logic [2:0] OP_INVERT    = 3'd3;
  localparam logic [2:0] OP_CLEAR_ALL = 3'd4;
  localparam logic [2:0] OP_SET_ALL   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  // Map select width: a single map still needs a one-bit select field.
  function automatic int map_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Ops that use the from/size range and can therefore be clipped.
  function automatic logic op_is_range(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_REMOVE) || (op == OP_INVERT);
  endfunction

endpackage

// File: rtl/page_map_bank_if.sv
// Command, status, map and lookup signals of the page map bank.
interface page_map_bank_if #(
  parameter int PAGES    = 256,
  parameter int NUM_MAPS = 2
);
  import page_map_bank_pkg::*;

  localparam int PAGE_W = $clog2(PAGES);
  localparam int MAP_W  = map_w(NUM_MAPS);

  // Command handshake: a command transfers on a rising edge where cmd_valid
  // and cmd_ready are both high. The source holds cmd_* stable until then;
  // cmd_ready is high only while the bank is idle, so a held cmd_valid is
  // taken at most once every three cycles.
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [MAP_W-1:0]          cmd_map;
  logic [PAGE_W-1:0]         cmd_from;
  logic [PAGE_W:0]           cmd_size;

  logic                      done;
  logic                      err;
  logic                      clipped;
  logic                      valid;
  logic [NUM_MAPS*PAGES-1:0] map_out;

  logic [MAP_W-1:0]          lk_map;
  logic [PAGE_W-1:0]         lk_page;
  logic                      lk_hit;

  modport master (
    output cmd_valid, cmd_op, cmd_map, cmd_from, cmd_size, lk_map, lk_page,
    input  cmd_ready, done, err, clipped, valid, map_out, lk_hit
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_map, cmd_from, cmd_size, lk_map, lk_page,
    output cmd_ready, done, err, clipped, valid, map_out, lk_hit
  );

endinterface

// File: rtl/page_map_bank_range_mask.sv
// Combinational range decoder: from/size to a one-hot-run page mask, with the
// end of the range clamped at the top page (ranges never wrap to page 0).
module range_mask #(
  parameter int PAGES = 256,
  localparam int PAGE_W = $clog2(PAGES)
) (
  input  logic [PAGE_W-1:0] i_from,
  input  logic [PAGE_W:0]   i_size,
  output logic [PAGES-1:0]  o_mask,
  output logic              o_clip
);

  // Two extra bits so from + size can never overflow before the clamp.
  localparam int EW = PAGE_W + 2;

  logic [EW-1:0] w_end;
  logic [EW-1:0] w_end_c;

  // Compute the clamped end and compare every page index against the range.
  always_comb begin
    w_end   = {2'b00, i_from} + {1'b0, i_size};
    o_clip  = (w_end > EW'(PAGES));
    w_end_c = o_clip ? EW'(PAGES) : w_end;
    for (int i = 0; i < PAGES; i++) begin
      o_mask[i] = ({2'b00, i_from} <= EW'(i)) && (EW'(i) < w_end_c);
    end
  end

endmodule

// File: rtl/page_map_bank.sv
// Bank of NUM_MAPS page maps updated by range commands (IDLE -> BUILD -> APPLY)
// with a registered single-page lookup for the A8 address decoder.
module page_map_bank
  import page_map_bank_pkg::*;
#(
  parameter int PAGES    = 256,
  parameter int NUM_MAPS = 2
) (
  input  logic            clk200,
  input  logic            a8_rst,
  page_map_bank_if.slave  bus,
  output state_t          o_dbg_state
);

  localparam int PAGE_W = $clog2(PAGES);
  localparam int MAP_W  = map_w(NUM_MAPS);

  state_t                           r_state;
  logic [2:0]                       r_op;
  logic [MAP_W-1:0]                 r_map;
  logic [PAGE_W-1:0]                r_from;
  logic [PAGE_W:0]                  r_size;
  logic [PAGES-1:0]                 r_mask;
  logic                             r_clip;
  logic [NUM_MAPS-1:0][PAGES-1:0]   r_maps;
  logic                             r_done;
  logic                             r_err;
  logic                             r_clipped;
  logic                             r_lk_hit;

  logic [PAGES-1:0]                 w_mask;
  logic                             w_clip;
  logic                             w_err;
  logic [PAGES-1:0]                 w_lk_row;

  range_mask #(.PAGES(PAGES)) u_range_mask (
    .i_from (r_from),
    .i_size (r_size),
    .o_mask (w_mask),
    .o_clip (w_clip)
  );

  // A bad map index or reserved opcode completes as an error with no update.
  assign w_err = (32'(r_map) >= NUM_MAPS) || (r_op > OP_SET_ALL);

  // Command FSM: latch on accept, register the mask, then apply and report.
  always_ff @(posedge clk200) begin
    if (a8_rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NONE;
      r_map     <= '0;
      r_from    <= '0;
      r_size    <= '0;
      r_mask    <= '0;
      r_clip    <= 1'b0;
      r_maps    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clipped <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clipped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op    <= bus.cmd_op;
            r_map   <= bus.cmd_map;
            r_from  <= bus.cmd_from;
            r_size  <= bus.cmd_size;
            r_state <= ST_BUILD;
          end
        end
        ST_BUILD: begin
          r_mask  <= w_mask;
          r_clip  <= w_clip;
          r_state <= ST_APPLY;
        end
        ST_APPLY: begin
          for (int k = 0; k < NUM_MAPS; k++) begin
            if (!w_err && (MAP_W'(k) == r_map)) begin
              case (r_op)
                OP_ADD:       r_maps[k] <= r_maps[k] | r_mask;
                OP_REMOVE:    r_maps[k] <= r_maps[k] & ~r_mask;
                OP_INVERT:    r_maps[k] <= r_maps[k] ^ r_mask;
                OP_CLEAR_ALL: r_maps[k] <= '0;
                OP_SET_ALL:   r_maps[k] <= '1;
                default:      r_maps[k] <= r_maps[k];
              endcase
            end
          end
          r_done    <= 1'b1;
          r_err     <= w_err;
          r_clipped <= !w_err && op_is_range(r_op) && r_clip;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Select the lookup row; an out-of-range map index selects all zeros.
  always_comb begin
    w_lk_row = '0;
    for (int k = 0; k < NUM_MAPS; k++) begin
      if (MAP_W'(k) == bus.lk_map) w_lk_row = r_maps[k];
    end
  end

  // Lookup register, running every cycle regardless of the FSM.
  always_ff @(posedge clk200) begin
    if (a8_rst) r_lk_hit <= 1'b0;
    else        r_lk_hit <= w_lk_row[bus.lk_page];
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.valid     = (r_state == ST_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.clipped   = r_clipped;
  assign bus.map_out   = r_maps;
  assign bus.lk_hit    = r_lk_hit;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_page_map_bank.sv
// Self-checking bench for page_map_bank: directed scenarios plus random
// commands, checked against an array model through an expected queue.
module tb_page_map_bank;
  import page_map_bank_pkg::*;

  localparam int PAGES    = 256;
  localparam int NUM_MAPS = 3;
  localparam int MAP_W    = 2;
  localparam int MW       = NUM_MAPS * PAGES;
  localparam int W        = MW + 2;

  // ---------------- clock / reset ----------------
  logic   clk200 = 1'b0;
  logic   a8_rst = 1'b1;
  state_t dbg_state;

  always #5 clk200 = ~clk200;

  page_map_bank_if #(.PAGES(PAGES), .NUM_MAPS(NUM_MAPS)) bus ();

  page_map_bank #(.PAGES(PAGES), .NUM_MAPS(NUM_MAPS)) dut (
    .clk200      (clk200),
    .a8_rst      (a8_rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [W-1:0]   exp_q[$];
  bit             mdl [NUM_MAPS][PAGES];
  logic [MW-1:0]  vis = '0;
  logic           prev_lk = 1'b0;
  bit             lk_hold = 1'b0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [MW-1:0] pack_mdl();
    logic [MW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_MAPS; k++)
      for (int i = 0; i < PAGES; i++)
        v[k*PAGES+i] = mdl[k][i];
    return v;
  endfunction

  task automatic clear_mdl();
    for (int k = 0; k < NUM_MAPS; k++)
      for (int i = 0; i < PAGES; i++)
        mdl[k][i] = 1'b0;
  endtask

  // Reference: apply a command to the page arrays directly.
  task automatic model_cmd(input logic [2:0] op, input int map, input int from, input int size,
                           output logic e, output logic c);
    int stop;
    e = (map >= NUM_MAPS) || (op > 3'd5);
    c = 1'b0;
    if (e) return;
    stop = from + size;
    if (stop > PAGES) begin
      stop = PAGES;
      c = (op >= 3'd1) && (op <= 3'd3);
    end
    for (int i = 0; i < PAGES; i++) begin
      case (op)
        3'd1: if (i >= from && i < stop) mdl[map][i] = 1'b1;
        3'd2: if (i >= from && i < stop) mdl[map][i] = 1'b0;
        3'd3: if (i >= from && i < stop) mdl[map][i] = ~mdl[map][i];
        3'd4: mdl[map][i] = 1'b0;
        3'd5: mdl[map][i] = 1'b1;
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  // Offers a command, pushes its expectation at the accepting edge, checks
  // the busy window and the done cycle; returns on the negedge of cycle 3.
  task automatic issue(input logic [2:0] op, input int map, input int from, input int size,
                       input bit keep);
    int   t;
    logic e, c;
    bus.cmd_op    = op;
    bus.cmd_map   = MAP_W'(map);
    bus.cmd_from  = 8'(from);
    bus.cmd_size  = 9'(size);
    bus.cmd_valid = 1'b1;
    t = 0;
    while (bus.cmd_ready !== 1'b1) begin
      @(negedge clk200);
      t++;
      if (t > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: cmd_ready stayed %b, want 1", bus.cmd_ready);
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk200);
    model_cmd(op, map, from, size, e, c);
    exp_q.push_back({e, c, pack_mdl()});
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk200);
      check("busy_valid", MW'(bus.valid), '0);
      check("busy_ready", MW'(bus.cmd_ready), '0);
      check("busy_done", MW'(bus.done), '0);
    end
    @(negedge clk200);
    check("done_cycle3", MW'(bus.done), MW'(1));
    check("ready_cycle3", MW'(bus.cmd_ready), MW'(1));
  endtask

  // Random lookup inputs, changed just after every rising edge.
  initial begin
    bus.lk_map  = '0;
    bus.lk_page = '0;
    forever begin
      @(posedge clk200);
      #1;
      if (!lk_hold) begin
        bus.lk_map  = MAP_W'($urandom_range(0, 3));
        bus.lk_page = 8'($urandom_range(0, PAGES - 1));
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] e;
    logic         rst_edge;
    forever begin
      @(posedge clk200);
      rst_edge = a8_rst;
      @(negedge clk200);
      if (rst_edge) begin
        vis = '0;
        check("rst_map_out", bus.map_out, '0);
        check("rst_done", MW'(bus.done), '0);
        check("rst_lk_hit", MW'(bus.lk_hit), '0);
        prev_lk = 1'b0;
      end else begin
        if (bus.done === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: done=1 with nothing outstanding at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("done_err", MW'(bus.err), MW'(e[W-1]));
            check("done_clipped", MW'(bus.clipped), MW'(e[W-2]));
            check("done_map", bus.map_out, e[MW-1:0]);
            vis = e[MW-1:0];
          end
        end
        check("map_out", bus.map_out, vis);
        check("lk_hit", MW'(bus.lk_hit), MW'(prev_lk));
        prev_lk = (int'(bus.lk_map) < NUM_MAPS) ?
                  vis[int'(bus.lk_map)*PAGES + int'(bus.lk_page)] : 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [255:0] pat;
    logic [2:0]   op;
    int           map, from, size;
    bit           keep;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_map   = '0;
    bus.cmd_from  = '0;
    bus.cmd_size  = '0;
    clear_mdl();

    repeat (3) @(posedge clk200);
    #1 a8_rst = 1'b0;
    @(negedge clk200);
    check("reset_ready", MW'(bus.cmd_ready), MW'(1));
    check("reset_valid", MW'(bus.valid), MW'(1));
    check("reset_err", MW'(bus.err), '0);
    check("reset_clipped", MW'(bus.clipped), '0);

    // Single range, then a range clipped at the top page.
    issue(OP_ADD, 0, 8'h10, 4, 1'b0);
    issue(OP_ADD, 1, 8'hFE, 8, 1'b0);
    check("clip_flag", MW'(bus.clipped), MW'(1));
    pat = 256'h3 << 254;
    check("map1_top", MW'(bus.map_out[511:256]), MW'(pat));

    // Full fill, remove a block, invert across the removal boundary.
    issue(OP_ADD, 0, 8'h00, 256, 1'b0);
    check("full_no_clip", MW'(bus.clipped), '0);
    issue(OP_REMOVE, 0, 8'h40, 8'h40, 1'b0);
    issue(OP_INVERT, 0, 8'h3C, 8, 1'b0);
    pat = '0;
    for (int i = 0; i < 256; i++)
      pat[i] = (i < 8'h3C) || (i >= 8'h40 && i < 8'h44) || (i >= 8'h80);
    check("map0_pattern", MW'(bus.map_out[255:0]), MW'(pat));

    // Empty range and error cases.
    issue(OP_ADD, 0, 8'h20, 0, 1'b0);
    check("size0_err", MW'(bus.err), '0);
    issue(OP_ADD, 3, 8'h20, 4, 1'b0);
    check("badmap_err", MW'(bus.err), MW'(1));
    issue(3'd6, 1, 8'h00, 16, 1'b0);
    issue(3'd7, 2, 8'h10, 16, 1'b0);
    issue(OP_NONE, 2, 8'h10, 16, 1'b0);

    // Lookup polled across an ADD that covers it.
    @(negedge clk200);
    lk_hold = 1'b1;
    bus.lk_map  = 2'd0;
    bus.lk_page = 8'h11;
    issue(OP_CLEAR_ALL, 0, 8'h00, 0, 1'b0);
    issue(OP_ADD, 0, 8'h10, 4, 1'b0);
    check("lk_pre_update", MW'(bus.lk_hit), '0);
    @(negedge clk200);
    check("lk_post_update", MW'(bus.lk_hit), MW'(1));
    lk_hold = 1'b0;

    // Reset during BUILD of SET_ALL aborts the command.
    bus.cmd_op    = OP_SET_ALL;
    bus.cmd_map   = 2'd2;
    bus.cmd_from  = '0;
    bus.cmd_size  = '0;
    bus.cmd_valid = 1'b1;
    @(posedge clk200);
    #1;
    bus.cmd_valid = 1'b0;
    a8_rst = 1'b1;
    @(negedge clk200);
    check("abort_in_build", MW'(dbg_state), MW'(ST_BUILD));
    repeat (2) @(posedge clk200);
    #1 a8_rst = 1'b0;
    clear_mdl();
    exp_q.delete();
    @(negedge clk200);
    check("post_rst_ready", MW'(bus.cmd_ready), MW'(1));
    check("post_rst_done", MW'(bus.done), '0);
    repeat (4) @(negedge clk200);

    // Back-to-back commands with cmd_valid held high throughout.
    issue(OP_SET_ALL, 1, 0, 0, 1'b1);
    issue(OP_REMOVE, 1, 5, 10, 1'b1);
    issue(OP_INVERT, 2, 100, 200, 1'b1);
    issue(OP_ADD, 2, 3, 3, 1'b0);

    // Random commands.
    keep = 1'b0;
    for (int n = 0; n < 60; n++) begin
      op   = 3'($urandom_range(0, 7));
      map  = $urandom_range(0, 3);
      from = $urandom_range(0, PAGES - 1);
      size = $urandom_range(0, PAGES);
      if ((op == OP_NONE || op > OP_SET_ALL || map >= NUM_MAPS) && (from + size > PAGES))
        size = PAGES - from;
      if (!keep && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk200);
      keep = (n == 59) ? 1'b0 : 1'($urandom_range(0, 1));
      issue(op, map, from, size, keep);
    end

    repeat (6) @(negedge clk200);
    check("queue_drained", MW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/page_map_bank.md
# page_map_bank

Parametrised successor to the single 256-page SDRAM map: holds NUM_MAPS independent PAGES-bit page maps (e.g. separate read/write or per-bank maps) that decide when SDRAM is mapped in for the A8. Range commands arrive over a valid/ready handshake and apply ADD / REMOVE / INVERT / CLEAR_ALL / SET_ALL. The range mask is computed arithmetically rather than from block-RAM, ranges are clipped at the top page, and a registered single-page lookup port serves the A8 address decoder.

## Interface
- PAGES, 256, pages per map; power of two, ≥ 2
- NUM_MAPS, 2, number of independent maps; ≥ 1
- PAGE_W, $clog2(PAGES), page index width (derived)
- MAP_W, max(1, $clog2(NUM_MAPS)), map select width (derived)
- Reset: one clock; reset is synchronous and active-high.
- clk200  in  1  200 MHz system clock; all logic on rising edge
- a8_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept; high only in IDLE
- cmd_op  in  3  opcode, values in page_map_pkg
- cmd_map  in  MAP_W  target map index
- cmd_from  in  PAGE_W  first page of range
- cmd_size  in  PAGE_W+1  page count, 0..PAGES inclusive
- done  out  1  one-cycle pulse when command completes
- err  out  1  with done: map index ≥ NUM_MAPS, or op reserved
- clipped  out  1  with done: range truncated at PAGES
- valid  out  1  all maps stable (state IDLE)
- map_out  out  NUM_MAPS*PAGES  flattened maps; map k = bits [k*PAGES +: PAGES]
- lk_map  in  MAP_W  lookup map select
- lk_page  in  PAGE_W  lookup page
- lk_hit  out  1  registered map[lk_map][lk_page]

## Operation
- Opcodes: OP_NONE=0, OP_ADD=1 (OR mask), OP_REMOVE=2 (AND ~mask), OP_INVERT=3 (XOR mask), OP_CLEAR_ALL=4 (map←0), OP_SET_ALL=5 (map←all 1s), 6–7 reserved.
- FSM: IDLE → BUILD → APPLY → IDLE.
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch op/map/from/size, go to BUILD. OP_NONE is accepted and completes with no change.
  - BUILD: end = from + size (PAGE_W+2 bits), clipped to PAGES. Register mask bit i = (from ≤ i < end_clipped). Register clip flag = (from + size > PAGES).
  - APPLY: update the target map per op, assert done/err/clipped on the next cycle, return to IDLE.
- size=0: empty mask; ADD/REMOVE/INVERT leave the map unchanged; done still pulses.
- CLEAR_ALL/SET_ALL ignore from/size. clipped=0 for them.
- Ranges never wrap to page 0.
- err cases (cmd_map ≥ NUM_MAPS, or reserved op): no map changes; done=1, err=1.
- Only the target map changes; all other maps hold.
- Lookup: lk_hit ← map[lk_map][lk_page] every cycle, independent of the FSM. If lk_map ≥ NUM_MAPS, lk_hit ← 0.

## Timing
- Reset values: all maps 0, state IDLE, cmd_ready=1, valid=1, done=err=clipped=0, lk_hit=0.
- Accept at edge E0. State is BUILD during cycle 1 and APPLY during cycle 2. The map updates at E2 and is visible on map_out in cycle 3. done pulses in cycle 3, where cmd_ready=1 again.
- Latency from accept to visible map is 3 cycles; maximum throughput is one command per 3 cycles.
- valid=0 during cycles 1–2.
- cmd_valid while not ready is not accepted. The source holds its fields until the handshake.
- lk_hit has 1-cycle latency. A lookup sampled on edge E2 sees the pre-update map.
- a8_rst mid-command aborts it. Maps clear, no done pulse, and cmd_ready=1 in the first cycle after reset deasserts.
- a8_rst has priority over cmd_valid on the same edge.

## Structure
- page_map_pkg holds OP_* localparams (3-bit) and state encodings. It replaces the `OP_* macros for this block.
- Sub-module range_mask (PAGES param): combinational from/size → mask + clip flag, registered in the parent in BUILD. It is unit-testable on its own.
- Parent holds the FSM, map storage as NUM_MAPS×PAGES registers, and the lookup register.

## Test plan
- Reset, then ADD map0 from=0x10 size=4 → map0 bits 0x10–0x13 set, all else 0; done in cycle 3, valid low in cycles 1–2.
- ADD map1 from=0xFE size=8 (PAGES=256) → only bits 0xFE–0xFF set; clipped=1; map0 unchanged.
- ADD 0x00/256, then REMOVE 0x40/0x40, then INVERT 0x3C/8 → bits 0x00–0x3B, 0x3C–0x3F cleared, 0x40–0x43 set, 0x80–0xFF set.
- size=0 ADD, and cmd_map=3 with NUM_MAPS=2 → map unchanged; done=1 both times, err=1 only for the second.
- Lookup lk_map=0 lk_page=0x11 polled across an ADD covering it → lk_hit 0 through the cycle after E2, then 1.
- Assert a8_rst during BUILD of SET_ALL → all maps 0, no done, cmd_ready=1 after reset; back-to-back commands held on cmd_valid accepted every 3 cycles.
